seq_add32: RTL and testbench

SEQ_ADD32 -- requirements
Module: seq_add32

---
 rtl/seq_add32.sv | 110 +++++++++++
 tb/tb_seq_add32.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_add32.sv
// Bit-serial-by-nibble 32-bit adder/subtractor: eight 4-bit slices through one
// carry-lookahead slice, one slice per clock, with registered flags.

module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];
endmodule

module seq_add32 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        co,
   output logic        ov,
   output logic        z,
   output logic        n
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [2:0]  cnt;
   logic        carry;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [4:0]  idx;
   logic [3:0]  slice_s;
   logic        slice_co;

   assign idx  = {cnt, 2'b00};
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   cla4 u_cla4 (
      .a  (a_r[idx +: 4]),
      .b  (b_r[idx +: 4]),
      .ci (carry),
      .s  (slice_s),
      .co (slice_co)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         carry  <= 1'b0;
         a_r    <= 32'd0;
         b_r    <= 32'd0;
         result <= 32'd0;
         co     <= 1'b0;
         ov     <= 1'b0;
         z      <= 1'b1;
         n      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= op ? ~b : b;
                  carry <= op;
                  cnt   <= 3'd0;
                  state <= RUN;
               end
            end
            RUN: begin
               result[idx +: 4] <= slice_s;
               carry            <= slice_co;
               cnt              <= cnt + 3'd1;
               // Top slice: flags come from the slice outputs since result is not yet updated.
               if (cnt == 3'd7) begin
                  co    <= slice_co;
                  ov    <= a_r[31] ^ b_r[31] ^ slice_s[3] ^ slice_co;
                  z     <= ({slice_s, result[27:0]} == 32'd0);
                  n     <= slice_s[3];
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_add32.sv
// Scoreboarded random/directed bench for seq_add32 with an arithmetic reference
// model; a monitor checks every done pulse against the expected queue.

module tb_seq_add32;
   logic        clk;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        co;
   logic        ov;
   logic        z;
   logic        n;

   int errors = 0;
   int checks = 0;
   int ops_issued = 0;
   int done_seen = 0;
   logic [35:0] exp_q[$];

   seq_add32 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .co      (co),
      .ov      (ov),
      .z       (z),
      .n       (n)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: packed {result, co, ov, z, n}
   function automatic logic [35:0] model(input logic [31:0] ta, input logic [31:0] tb,
                                         input logic top);
      logic [32:0] s;
      logic [31:0] r;
      logic        c;
      logic        v;
      if (!top) s = {1'b0, ta} + {1'b0, tb};
      else      s = {1'b0, ta} + {1'b0, ~tb} + 33'd1;
      r = s[31:0];
      c = s[32];
      if (!top) v = (ta[31] == tb[31]) && (r[31] != ta[31]);
      else      v = (ta[31] != tb[31]) && (r[31] != ta[31]);
      return {r, c, v, (r == 32'd0), r[31]};
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (reset_n && done) begin
         logic [35:0] e;
         done_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("result", result, e[35:4]);
            chk("flags_co_ov_z_n", {28'd0, co, ov, z, n}, {28'd0, e[3:0]});
         end
      end
   end

   // driver: issues one op and checks busy/done timing and hold-after-done
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                        input bit inject);
      logic [35:0] e;
      @(negedge clk);
      a = ta;
      b = tb;
      op = top;
      start = 1'b1;
      e = model(ta, tb, top);
      exp_q.push_back(e);
      ops_issued++;
      @(posedge clk);              // T0
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);           // cycle after edge Tk-1... sampled after Tk
         if (k == 1) begin
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            op = 1'($urandom_range(0, 1));
         end
         if (inject && k == 2) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            op = 1'($urandom_range(0, 1));
         end
         if (inject && k == 3) start = 1'b0;
         chk("busy_in_flight", {31'd0, busy}, 32'd1);
         chk("done_timing", {31'd0, done}, {31'd0, (k == 9)});
      end
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("result_hold", result, e[35:4]);
      chk("flags_hold", {28'd0, co, ov, z, n}, {28'd0, e[3:0]});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_result"}, result, 32'd0);
      chk({tag, "_co_ov_z_n"}, {28'd0, co, ov, z, n}, 32'h2);
      chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      op = 1'b0;
      a = 32'd0;
      b = 32'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_state");
      reset_n = 1'b1;

      // directed cases
      do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      do_op(32'd5, 32'd3, 1'b1, 1'b0);
      do_op(32'd3, 32'd5, 1'b1, 1'b0);
      do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
      do_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);

      // randomized, biased toward carry/borrow boundaries
      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ~ra + 32'($urandom_range(0, 2));
            1: rb = ra;
            2: ra = {1'b0, 31'($urandom)} | 32'h7000_0000;
            default: ;
         endcase
         do_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end

      // reset in the middle of an operation
      @(negedge clk);
      a = 32'hDEAD_BEEF;
      b = 32'h1111_1111;
      op = 1'b0;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      @(posedge clk);              // T0+4
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("reset_mid_run");
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("busy_held_in_reset", {31'd0, busy}, 32'd0);
      end
      start = 1'b0;
      reset_n = 1'b1;
      do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("done_pulse_count", done_seen, ops_issued);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
